// File: rtl/nvram_pkg.sv
// rtl/nvram_pkg.sv - shared types and helpers for the NVRAM upload responder
package nvram_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  localparam logic [7:0] OOR_BYTE = 8'hFF;

  // True when the HPS byte address falls inside a 2^addr_w entry CMOS RAM.
  function automatic logic in_range(input logic [16:0] addr, input int unsigned addr_w);
    logic [16:0] hi;
    hi = addr >> addr_w;
    return (hi == 17'd0);
  endfunction

endpackage

// File: rtl/nvram_dirty_timer.sv
// rtl/nvram_dirty_timer.sv - tracks CMOS writes and requests a save after a quiet period
module nvram_dirty_timer
  import nvram_pkg::*;
#(
  parameter int QUIET_TICKS = 12000000,
  parameter int CNT_W       = 24
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic cmos_we,
  input  logic ioctl_upload,
  output logic upload_req
);

  localparam logic [CNT_W-1:0] QUIET = CNT_W'(QUIET_TICKS);

  logic             dirty_q, dirty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;

  always_comb begin
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    if (dirty_q && (cnt_q == QUIET) && !ioctl_upload) begin
      req_d   = 1'b1;
      dirty_d = 1'b0;
      cnt_d   = '0;
    end else if (dirty_q && (cnt_q != QUIET)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A write in the firing cycle still lets the pulse out but re-arms the timer.
    if (cmos_we) begin
      dirty_d = 1'b1;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dirty_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign upload_req = req_q;

endmodule

// File: rtl/nvram_upload.sv
// rtl/nvram_upload.sv - serves battery-backed CMOS RAM to the HPS over ioctl_upload
module nvram_upload
  import nvram_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 4,
  parameter int QUIET_TICKS = 12000000,
  parameter int CNT_W       = 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [16:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              cmos_we
);

  state_e            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    wait_d  = wait_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        wait_d = 1'b0;
        if (ioctl_rd && ioctl_upload) begin
          if (in_range(ioctl_addr, ADDR_W)) begin
            req_d   = 1'b1;
            addr_d  = ioctl_addr[ADDR_W-1:0];
            wait_d  = 1'b1;
            state_d = FETCH;
          end else begin
            din_d = OOR_BYTE;
          end
        end
      end
      // The RAM access is always completed, even if the upload has ended meanwhile.
      FETCH: begin
        if (ram_ack) begin
          din_d   = 8'(ram_dout);
          req_d   = 1'b0;
          wait_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign ram_req    = req_q;
  assign ram_addr   = addr_q;

  nvram_dirty_timer #(
    .QUIET_TICKS(QUIET_TICKS),
    .CNT_W      (CNT_W)
  ) u_dirty_timer (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cmos_we     (cmos_we),
    .ioctl_upload(ioctl_upload),
    .upload_req  (ioctl_upload_req)
  );

endmodule

// File: tb/tb_nvram_upload.sv
// tb/tb_nvram_upload.sv - directed self-checking bench for nvram_upload
module tb_nvram_upload;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_upload = 1'b0;
  logic              ioctl_rd = 1'b0;
  logic [16:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              ioctl_upload_req;
  logic              ram_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ack = 1'b0;
  logic [DATA_W-1:0] ram_dout = '0;
  logic              cmos_we = 1'b0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .QUIET_TICKS(100), .CNT_W(8)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .ioctl_upload_req(ioctl_upload_req),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_ack(ram_ack),
    .ram_dout(ram_dout), .cmos_we(cmos_we)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drives cmos_we at the listed edges (edge 0 first) and reports upload_req pulses.
  task automatic run_quiet(input int w0, input int w1, input int w2, input int last,
                           output int pulses, output int first_at);
    pulses   = 0;
    first_at = -1;
    for (int n = 0; n <= last; n++) begin
      cmos_we = (n == w0) || (n == w1) || (n == w2);
      tick();
      if (ioctl_upload_req === 1'b1) begin
        if (pulses == 0) first_at = n;
        pulses++;
      end
    end
    cmos_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (ioctl_din !== 8'h00) begin n_bad++; $display("FAIL reset_din got %h want 00", ioctl_din); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
    n_cmp++; if (ioctl_upload_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", ioctl_upload_req); end
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL reset_ram_req got %b want 0", ram_req); end
    n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read_in_range();
    ioctl_upload = 1'b1;
    ioctl_addr   = 17'd5;
    ioctl_rd     = 1'b1;
    tick();
    n_cmp++; if (ram_req !== 1'b1) begin n_bad++; $display("FAIL rd_req got %b want 1", ram_req); end
    n_cmp++; if (ram_addr !== 10'd5) begin n_bad++; $display("FAIL rd_addr got %h want 005", ram_addr); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL rd_wait1 got %b want 1", ioctl_wait); end
    ioctl_addr = 17'd7;  // read while busy must be ignored
    tick();
    ioctl_rd = 1'b0;
    n_cmp++; if (ram_addr !== 10'd5) begin n_bad++; $display("FAIL busy_rd_addr got %h want 005", ram_addr); end
    n_cmp++; if (ioctl_wait !== 1'b1 || ram_req !== 1'b1) begin n_bad++; $display("FAIL rd_hold got wait=%b req=%b want 1/1", ioctl_wait, ram_req); end
    ram_ack  = 1'b1;
    ram_dout = mem[ram_addr];
    tick();
    ram_ack = 1'b0;
    n_cmp++; if (ioctl_din !== 8'h0A) begin n_bad++; $display("FAIL rd_din got %h want 0a", ioctl_din); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL rd_wait_end got %b want 0", ioctl_wait); end
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_end got %b want 0", ram_req); end
    tick();
    tick();
    n_cmp++; if (ioctl_din !== 8'h0A || ram_req !== 1'b0) begin n_bad++; $display("FAIL rd_hold_din got din=%h req=%b want 0a/0", ioctl_din, ram_req); end
  endtask

  task automatic test_out_of_range();
    int req_seen;
    req_seen     = 0;
    ioctl_upload = 1'b1;
    ioctl_addr   = 17'h00400;
    ioctl_rd     = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    if (ram_req === 1'b1) req_seen++;
    n_cmp++; if (ioctl_din !== 8'hFF) begin n_bad++; $display("FAIL oor_din got %h want ff", ioctl_din); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL oor_wait got %b want 0", ioctl_wait); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ram_req === 1'b1) req_seen++;
    end
    n_cmp++; if (req_seen != 0) begin n_bad++; $display("FAIL oor_ram_req got %0d cycles want 0", req_seen); end
    // rd without upload is ignored
    ioctl_upload = 1'b0;
    ioctl_addr   = 17'd3;
    ioctl_rd     = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n_cmp++; if (ram_req !== 1'b0 || ioctl_din !== 8'hFF) begin n_bad++; $display("FAIL noupl_rd got req=%b din=%h want 0/ff", ram_req, ioctl_din); end
    tick();
  endtask

  task automatic test_quiet_single();
    int pulses, at;
    ioctl_upload = 1'b0;
    run_quiet(0, -1, -1, 1100, pulses, at);
    n_cmp++; if (at != 101) begin n_bad++; $display("FAIL quiet1_at got %0d want 101", at); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL quiet1_count got %0d want 1", pulses); end
  endtask

  task automatic test_quiet_restart();
    int pulses, at;
    ioctl_upload = 1'b0;
    run_quiet(0, 50, 140, 600, pulses, at);
    n_cmp++; if (at != 241) begin n_bad++; $display("FAIL quiet3_at got %0d want 241", at); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL quiet3_count got %0d want 1", pulses); end
  endtask

  task automatic test_upload_block();
    int pulses, at;
    ioctl_upload = 1'b1;
    run_quiet(0, -1, -1, 150, pulses, at);
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL block_count got %0d want 0", pulses); end
    ioctl_upload = 1'b0;
    tick();
    n_cmp++; if (ioctl_upload_req !== 1'b1) begin n_bad++; $display("FAIL block_release got %b want 1", ioctl_upload_req); end
    tick();
    n_cmp++; if (ioctl_upload_req !== 1'b0) begin n_bad++; $display("FAIL block_single got %b want 0", ioctl_upload_req); end
  endtask

  task automatic test_reset_in_fetch();
    ioctl_upload = 1'b1;
    ioctl_addr   = 17'd5;
    ioctl_rd     = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n_cmp++; if (ram_req !== 1'b1) begin n_bad++; $display("FAIL rf_req got %b want 1", ram_req); end
    reset_n = 1'b0;
    tick();
    n_cmp++; if (ram_req !== 1'b0 || ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL rf_abort got req=%b wait=%b want 0/0", ram_req, ioctl_wait); end
    reset_n  = 1'b1;
    ram_ack  = 1'b1;
    ram_dout = 4'h7;
    tick();
    ram_ack = 1'b0;
    n_cmp++; if (ioctl_din !== 8'h00 || ram_req !== 1'b0) begin n_bad++; $display("FAIL rf_late_ack got din=%h req=%b want 00/0", ioctl_din, ram_req); end
    ioctl_addr = 17'd6;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n_cmp++; if (ram_req !== 1'b1 || ram_addr !== 10'd6) begin n_bad++; $display("FAIL rf_next_req got req=%b addr=%h want 1/006", ram_req, ram_addr); end
    ram_ack  = 1'b1;
    ram_dout = mem[ram_addr];
    tick();
    ram_ack = 1'b0;
    n_cmp++; if (ioctl_din !== 8'h03) begin n_bad++; $display("FAIL rf_next_din got %h want 03", ioctl_din); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[5] = 4'hA;
    mem[6] = 4'h3;
    test_reset();
    test_read_in_range();
    test_out_of_range();
    test_quiet_single();
    test_quiet_restart();
    test_upload_block();
    test_reset_in_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
